// File: rtl/calc_pkg.sv
// Shared calculator datapath definitions: FSM state encoding, opcode values,
// and the default operand width.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

endpackage : calc_pkg

// File: rtl/full_adder.sv
// Single-bit full adder built from two half adders plus an OR of their carries.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (w_s0),
    .c_o (w_c0)
  );

  half_adder u_ha1 (
    .a_i (w_s0),
    .b_i (c_i),
    .s_o (s_o),
    .c_o (w_c1)
  );

  assign c_o = w_c0 | w_c1;

endmodule : full_adder

// File: rtl/half_adder.sv
// Single-bit half adder: sum and carry of two input bits.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule : half_adder

// File: rtl/serial_adder_unit.sv
// Bit-serial add/subtract engine: one result bit per clock through a single
// full adder, with valid/ready handshakes on both sides.
module serial_adder_unit
  import calc_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             ovf_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_e           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic             r_carry;
  logic             r_c_msb_in;
  logic [CW-1:0]    r_cnt;

  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic             r_ovf;

  logic             w_sum;
  logic             w_cout;
  logic             w_is_sub;

  assign w_is_sub = (sub_i == OP_SUB);

  full_adder u_fa (
    .a_i (r_a_sh[0]),
    .b_i (r_b_sh[0]),
    .c_i (r_carry),
    .s_o (w_sum),
    .c_o (w_cout)
  );

  // FSM, operand/result shift registers, bit counter and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_a_sh      <= {WIDTH{1'b0}};
      r_b_sh      <= {WIDTH{1'b0}};
      r_res_sh    <= {WIDTH{1'b0}};
      r_carry     <= 1'b0;
      r_c_msb_in  <= 1'b0;
      r_cnt       <= {CW{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_carry_out <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          if (in_valid_i && r_in_ready) begin
            r_a_sh     <= a_i;
            r_b_sh     <= b_i ^ {WIDTH{w_is_sub}};
            r_carry    <= w_is_sub;
            r_c_msb_in <= 1'b0;
            r_cnt      <= {CW{1'b0}};
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end else begin
            r_in_ready <= 1'b1;
          end
        end

        RUN: begin
          r_res_sh <= {w_sum, r_res_sh[WIDTH-1:1]};
          r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_carry  <= w_cout;
          r_cnt    <= r_cnt + CNT_ONE;
          // Carry into the MSB, needed for the signed-overflow flag.
          if (r_cnt == CNT_MSB_IN) begin
            r_c_msb_in <= w_cout;
          end else begin
            r_c_msb_in <= r_c_msb_in;
          end
          if (r_cnt == CNT_LAST) begin
            r_state <= DONE;
          end else begin
            r_state <= RUN;
          end
        end

        DONE: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_result    <= r_res_sh;
            r_carry_out <= r_carry;
            r_ovf       <= r_c_msb_in ^ r_carry;
          end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign result_o    = r_result;
  assign carry_o     = r_carry_out;
  assign ovf_o       = r_ovf;

endmodule : serial_adder_unit
